// File: rtl/tc_to_sm_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, copy-until-first-one-then-invert.
// Optional build macro TC_TO_SM_SAT_EN saturates the magnitude of the most negative input.
module tc_to_sm_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-2:0] out_mag,
  output logic             out_ovf,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             sign, seen_one, r, last;
  logic [WIDTH-2:0] mag_fin;
  logic             ovf_fin;

  // Negative operands invert every bit above the first one; positives pass through.
  assign r       = sign ? (sr[0] ^ seen_one) : sr[0];
  assign res_nxt = {r, res[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH-1));
  assign ovf_fin = sign & res_nxt[WIDTH-1];

`ifdef TC_TO_SM_SAT_EN
  assign mag_fin = ovf_fin ? {(WIDTH-1){1'b1}} : res_nxt[WIDTH-2:0];
`else
  assign mag_fin = res_nxt[WIDTH-2:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CONV;
      CONV:    if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      res      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      seen_one <= 1'b0;
      out_sign <= 1'b0;
      out_mag  <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sr       <= in_data;
          sign     <= in_data[WIDTH-1];
          seen_one <= 1'b0;
          cnt      <= '0;
        end
        CONV: begin
          res      <= res_nxt;
          sr       <= {1'b0, sr[WIDTH-1:1]};
          seen_one <= seen_one | sr[0];
          cnt      <= cnt + 1'b1;
          // Outputs load once, on the final bit, and then hold until the next result.
          if (last) begin
            out_sign <= sign;
            out_mag  <= mag_fin;
            out_ovf  <= ovf_fin;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
